lii_pack_join: RTL and testbench

- Parametrised successor to the fixed-lane LII output pack wrappers.
- Joins NLANE independent HLS kernel output streams of LW bits each into one PW-bit LII phy output beat.
- Per-lane holding slots let lanes arrive on different cycles; a registered output stage removes the combinational tvalid path.
- Adds frame-boundary marking (tlast) and a beat counter; drives the kernel clock enable.

---
 rtl/lii_pack_join.sv | 125 ++++++++++++
 tb/tb_lii_pack_join.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_pack_join.sv
// rtl/lii_pack_join.sv - joins NLANE kernel output lanes into one registered LII phy beat
module lii_pack_join #(
    parameter int         NLANE       = 6,
    parameter int         LW          = 17,
    parameter int         PW          = 128,
    parameter logic [7:0] SRC_ID      = 8'h00,
    parameter logic [7:0] DST_ID      = 8'h00,
    parameter int         FRAME_BEATS = 0
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic [NLANE*LW-1:0]   s_tdata,
    input  logic [NLANE-1:0]      s_tvalid,
    output logic [NLANE-1:0]      s_tready,
    output logic [PW-1:0]         lii_out_tdata,
    output logic                  lii_out_tvalid,
    input  logic                  lii_out_tready,
    output logic                  lii_out_tlast,
    output logic [7:0]            lii_out_src,
    output logic [7:0]            lii_out_dst,
    output logic                  ce,
    output logic [31:0]           beat_cnt
);

    generate
        if (NLANE < 1 || NLANE > 16 || NLANE * LW > PW) begin : g_bad_cfg
            $error("lii_pack_join: NLANE must be 1..16 and NLANE*LW must fit in PW");
        end
    endgenerate

    logic [NLANE-1:0] full;
    logic [NLANE-1:0] accept;
    logic [LW-1:0]    slot_data [NLANE];
    logic             rst_done;
    logic             out_free;
    logic             xfer;
    logic             tlast_next;
    logic [PW-1:0]    beat_word;

    assign out_free    = ~lii_out_tvalid | lii_out_tready;
    assign xfer        = (&full) & out_free;
    // A full lane may still accept in the cycle its slot drains into the output stage.
    assign s_tready    = {NLANE{rst_done}} & (~full | {NLANE{xfer}});
    assign accept      = s_tvalid & s_tready;
    assign ce          = &s_tready;
    assign lii_out_src = SRC_ID;
    assign lii_out_dst = DST_ID;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            full <= '0;
            for (int i = 0; i < NLANE; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                if (accept[i]) begin
                    full[i]      <= 1'b1;
                    slot_data[i] <= s_tdata[i*LW +: LW];
                end else if (xfer) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Lane 0 lands in the most significant field; unused upper bits stay zero.
    always_comb begin
        beat_word = '0;
        for (int i = 0; i < NLANE; i++) begin
            beat_word[(NLANE-i)*LW-1 -: LW] = slot_data[i];
        end
    end

    generate
        if (FRAME_BEATS > 0) begin : g_frame
            localparam int            CW   = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
            localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);
            logic [CW-1:0] frame_cnt;

            assign tlast_next = (frame_cnt == LAST);

            always_ff @(posedge aclk or negedge arstn) begin
                if (!arstn) begin
                    frame_cnt <= '0;
                end else if (xfer) begin
                    frame_cnt <= tlast_next ? '0 : frame_cnt + CW'(1);
                end
            end
        end else begin : g_no_frame
            assign tlast_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            lii_out_tvalid <= 1'b0;
            lii_out_tdata  <= '0;
            lii_out_tlast  <= 1'b0;
        end else if (xfer) begin
            lii_out_tvalid <= 1'b1;
            lii_out_tdata  <= beat_word;
            lii_out_tlast  <= tlast_next;
        end else if (lii_out_tready) begin
            lii_out_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt <= '0;
        end else if (lii_out_tvalid && lii_out_tready) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_lii_pack_join.sv
// tb/tb_lii_pack_join.sv - directed bench with a lane-queue model for lii_pack_join
module tb_lii_pack_join;
    localparam int NLANE = 6;
    localparam int LW    = 17;
    localparam int PW    = 128;
    localparam int FB    = 4;

    logic                aclk = 1'b0;
    logic                arstn;
    logic [NLANE*LW-1:0] s_tdata;
    logic [NLANE-1:0]    s_tvalid;
    logic [NLANE-1:0]    s_tready;
    logic [PW-1:0]       tdata;
    logic                tvalid, tready, tlast, ce;
    logic [7:0]          src, dst;
    logic [31:0]         beat_cnt;

    logic [127:0] s2_tdata;
    logic [3:0]   s2_tvalid, s2_tready;
    logic [127:0] tdata2;
    logic         tvalid2, tready2, tlast2, ce2;
    logic [7:0]   src2, dst2;
    logic [31:0]  beat_cnt2;

    always #5 aclk = ~aclk;

    lii_pack_join #(.NLANE(NLANE), .LW(LW), .PW(PW), .SRC_ID(8'h5A), .DST_ID(8'hC3), .FRAME_BEATS(FB)) dut (
        .aclk(aclk), .arstn(arstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .lii_out_tdata(tdata), .lii_out_tvalid(tvalid), .lii_out_tready(tready), .lii_out_tlast(tlast),
        .lii_out_src(src), .lii_out_dst(dst), .ce(ce), .beat_cnt(beat_cnt));

    lii_pack_join #(.NLANE(4), .LW(32), .PW(128)) dut4 (
        .aclk(aclk), .arstn(arstn), .s_tdata(s2_tdata), .s_tvalid(s2_tvalid), .s_tready(s2_tready),
        .lii_out_tdata(tdata2), .lii_out_tvalid(tvalid2), .lii_out_tready(tready2), .lii_out_tlast(tlast2),
        .lii_out_src(src2), .lii_out_dst(dst2), .ce(ce2), .beat_cnt(beat_cnt2));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: per-lane queues of accepted words, one output stage, counters.
    logic [LW-1:0]  lane_q [NLANE][$];
    bit             ov_m, tl_m, rd_m;
    logic [PW-1:0]  od_m;
    int unsigned    loaded_m;
    logic [31:0]    bc_m;
    bit [NLANE-1:0] acc_m;

    always @(negedge aclk) begin : model
        bit             all_full, xf;
        logic [NLANE-1:0] rdy;
        logic [PW-1:0]  b;
        if (!arstn) begin
            for (int i = 0; i < NLANE; i++) lane_q[i].delete();
            ov_m = 0; tl_m = 0; od_m = '0; rd_m = 0; loaded_m = 0; bc_m = '0; acc_m = '0;
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tdata", tdata, 0);
            chk("rst_beat_cnt", beat_cnt, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_ce", ce, 0);
        end else begin
            all_full = 1;
            for (int i = 0; i < NLANE; i++) if (lane_q[i].size() == 0) all_full = 0;
            xf = all_full && (!ov_m || tready);
            for (int i = 0; i < NLANE; i++) rdy[i] = rd_m && (lane_q[i].size() == 0 || xf);
            chk("s_tready", s_tready, rdy);
            chk("ce", ce, &rdy);
            chk("tvalid", tvalid, ov_m);
            chk("beat_cnt", beat_cnt, bc_m);
            chk("src_dst", {src, dst}, 16'h5AC3);
            if (ov_m) begin
                chk("tdata", tdata, od_m);
                chk("tlast", tlast, tl_m);
            end
            if (ov_m && tready) bc_m = bc_m + 32'd1;
            if (xf) begin
                b = '0;
                for (int i = 0; i < NLANE; i++) b = (b << LW) | PW'(lane_q[i].pop_front());
                ov_m = 1; od_m = b;
                tl_m = ((loaded_m % FB) == FB - 1);
                loaded_m++;
            end else if (tready) begin
                ov_m = 0;
            end
            for (int i = 0; i < NLANE; i++) begin
                acc_m[i] = s_tvalid[i] && rdy[i];
                if (acc_m[i]) lane_q[i].push_back(s_tdata[i*LW +: LW]);
            end
            rd_m = 1;
        end
    end

    // Lane driver: each lane offers words until its sent count reaches its budget.
    int budget [NLANE];
    int sent   [NLANE];
    bit fixed_mode;

    function automatic logic [LW-1:0] lane_val(input int i, input int n);
        if (fixed_mode) return LW'(32'h100 + i);
        return LW'(32'h400 + n * 16 + i);
    endfunction

    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < NLANE; i++) begin
            if (acc_m[i]) sent[i]++;
            s_tvalid[i] = (sent[i] < budget[i]);
            s_tdata[i*LW +: LW] = lane_val(i, sent[i]);
        end
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic stop_and_drain();
        for (int i = 0; i < NLANE; i++) budget[i] = sent[i];
        repeat (6) step();
    endtask

    task automatic restart(input bit fixed);
        arstn = 1'b0;
        fixed_mode = fixed;
        for (int i = 0; i < NLANE; i++) begin budget[i] = 0; sent[i] = 0; end
        repeat (2) step();
        arstn = 1'b1;
    endtask

    initial begin
        int k, bc0, bc1;
        logic [PW-1:0] td;
        bit seen;
        arstn = 1'b0; tready = 1'b0; tready2 = 1'b0;
        s_tvalid = '0; s_tdata = '0; s2_tvalid = '0; s2_tdata = '0;
        fixed_mode = 1;
        for (int i = 0; i < NLANE; i++) begin budget[i] = 0; sent[i] = 0; end
        repeat (2) step();
        chk("lit_rst_tvalid", tvalid, 0);
        chk("lit_rst_tready", s_tready, 0);

        // Streaming with constant lane data, checking latency and layout.
        tready = 1'b1;
        for (int i = 0; i < NLANE; i++) budget[i] = 1000;
        arstn = 1'b1;
        step();
        chk("lit_ready_after_release", s_tready, 6'h3f);
        chk("lit_tvalid_edge1", tvalid, 0);
        step();
        chk("lit_tvalid_accept_edge", tvalid, 0);
        step();
        chk("lit_tvalid_latency", tvalid, 1);
        chk("lit_lane0_field", tdata[101:85], 17'h100);
        chk("lit_lane5_field", tdata[16:0], 17'h105);
        chk("lit_pad_zero", tdata[127:102], 0);
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("lit_stream_valid", tvalid, 1);
            chk("lit_stream_beat_cnt", beat_cnt, c);
        end
        stop_and_drain();

        // Staggered lane arrival produces exactly one beat.
        fixed_mode = 0;
        bc0 = beat_cnt;
        for (int l = 0; l < NLANE; l++) begin
            budget[l] = sent[l] + 1;
            step(); step();
            if (l < NLANE - 1) begin
                chk("lit_stagger_ready_drop", s_tready[l], 0);
                chk("lit_stagger_ce", ce, 0);
            end
        end
        repeat (3) step();
        chk("lit_stagger_one_beat", beat_cnt - bc0, 1);
        stop_and_drain();

        // Backpressure stall with full slots.
        for (int i = 0; i < NLANE; i++) budget[i] = sent[i] + 20;
        repeat (4) step();
        tready = 1'b0;
        step();
        td = tdata;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("lit_stall_valid", tvalid, 1);
            chk("lit_stall_data", tdata, td);
            chk("lit_stall_ready", s_tready, 0);
            chk("lit_stall_ce", ce, 0);
        end
        tready = 1'b1;
        bc1 = beat_cnt;
        step(); step();
        chk("lit_stall_release", beat_cnt, bc1 + 2);
        stop_and_drain();

        // Frame marking: tlast on beats 4 and 8 after reset.
        restart(0);
        for (int i = 0; i < NLANE; i++) budget[i] = 10;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            step();
            if (tvalid) begin
                k++;
                chk("lit_frame_tlast", tlast, (k == 4 || k == 8));
            end
        end
        chk("lit_frame_count", k, 10);
        stop_and_drain();

        // Mid-operation reset with lanes 0..2 held.
        for (int i = 0; i < NLANE; i++) begin budget[i] = 0; sent[i] = 0; end
        step();
        for (int i = 0; i < 3; i++) budget[i] = 2;
        repeat (4) step();
        chk("lit_partial_ready", s_tready, 6'h38);
        arstn = 1'b0;
        #1;
        chk("lit_async_tvalid", tvalid, 0);
        chk("lit_async_ready", s_tready, 0);
        chk("lit_async_ce", ce, 0);
        step();
        arstn = 1'b1;
        #1;
        chk("lit_release_ready_low", s_tready, 0);
        step();
        chk("lit_release_ready_high", s_tready, 6'h3f);
        for (int i = 3; i < NLANE; i++) budget[i] = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (tvalid) seen = 1;
        end
        chk("lit_post_rst_seen", seen, 1);
        chk("lit_post_rst_lane0", tdata[101:85], 17'h410);
        chk("lit_post_rst_lane5", tdata[16:0], 17'h405);
        stop_and_drain();

        // Four 32-bit lanes fill the full 128-bit beat.
        tready2 = 1'b1;
        s2_tdata = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        s2_tvalid = 4'hf;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (tvalid2) seen = 1;
        end
        chk("lit_w32_seen", seen, 1);
        chk("lit_w32_tdata", tdata2, 128'hA0000000_A0000001_A0000002_A0000003);
        s2_tvalid = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
